// File: rtl/if_id_stage_pkg.sv
// Shared ISA definitions for the IF/ID boundary: word width, bubble encoding,
// the immediate-class prefix and the assembler FSM states.
package if_id_stage_pkg;

    localparam int                 INSTR_W    = 16;
    localparam logic [INSTR_W-1:0] NOP_DEFAULT = 16'h0000;
    localparam logic [1:0]         IMM_PREFIX = 2'b11;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    // A word whose top two bits match the prefix carries a trailing immediate word.
    function automatic logic is_imm_class(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 2] == IMM_PREFIX;
    endfunction

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: passes single-word instructions through in one cycle and
// joins an immediate-class opcode word with the following word into one decode packet.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = NOP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [INSTR_WIDTH-1:0] if_instr,
    input  logic [ADDR_WIDTH-1:0]  if_pc,
    input  logic                   stall,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [INSTR_WIDTH-1:0] id_imm,
    output logic                   id_has_imm,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [ADDR_WIDTH-1:0]  id_pc_next,
    output logic                   id_valid
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_TWO = ADDR_WIDTH'(2);

    state_t                  state;
    state_t                  state_next;
    logic [INSTR_WIDTH-1:0]  op_hold;
    logic [ADDR_WIDTH-1:0]   pc_hold;
    logic                    take;
    logic                    word_is_imm;

    assign take        = if_valid && !stall && !flush;
    assign word_is_imm = is_imm_class(if_instr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_OP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_OP;
        end else if (take) begin
            case (state)
                S_OP:    state_next = word_is_imm ? S_IMM : S_OP;
                S_IMM:   state_next = S_OP;
                default: state_next = S_OP;
            endcase
        end
    end

    // Output packet and pending opcode; PCs are only updated when a packet is emitted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_instr   <= NOP_WORD;
            id_imm     <= '0;
            id_has_imm <= 1'b0;
            id_pc      <= '0;
            id_pc_next <= '0;
            id_valid   <= 1'b0;
            op_hold    <= '0;
            pc_hold    <= '0;
        end else if (flush || (!stall && !if_valid)) begin
            id_instr   <= NOP_WORD;
            id_imm     <= '0;
            id_has_imm <= 1'b0;
            id_valid   <= 1'b0;
        end else if (!stall) begin
            if (state == S_IMM) begin
                // The word after an imm-class opcode is always data, never an opcode.
                id_instr   <= op_hold;
                id_imm     <= if_instr;
                id_has_imm <= 1'b1;
                id_pc      <= pc_hold;
                id_pc_next <= pc_hold + PC_TWO;
                id_valid   <= 1'b1;
            end else if (word_is_imm) begin
                op_hold    <= if_instr;
                pc_hold    <= if_pc;
                id_instr   <= NOP_WORD;
                id_imm     <= '0;
                id_has_imm <= 1'b0;
                id_valid   <= 1'b0;
            end else begin
                id_instr   <= if_instr;
                id_imm     <= '0;
                id_has_imm <= 1'b0;
                id_pc      <= if_pc;
                id_pc_next <= if_pc + PC_ONE;
                id_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a word-queue reference model predicts every cycle's
// registered packet, and a monitor compares the DUT outputs one cycle later.
module tb_if_id_stage;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic        has_imm;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        valid;
    } pkt_t;

    typedef struct packed {
        logic [15:0] word;
        logic [31:0] pc;
    } fetched_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] id_instr;
    logic [15:0] id_imm;
    logic        id_has_imm;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;
    logic        id_valid;

    int vectors = 0;
    int miscompares = 0;

    pkt_t     exp_q[$];
    fetched_t pend[$];
    pkt_t     model_out;

    if_id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .stall(stall), .flush(flush), .id_instr(id_instr), .id_imm(id_imm),
        .id_has_imm(id_has_imm), .id_pc(id_pc), .id_pc_next(id_pc_next), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_pkt(input string tag, input pkt_t e);
        check({tag, ".instr"},   32'(id_instr),   32'(e.instr));
        check({tag, ".imm"},     32'(id_imm),     32'(e.imm));
        check({tag, ".has_imm"}, 32'(id_has_imm), 32'(e.has_imm));
        check({tag, ".pc"},      id_pc,           e.pc);
        check({tag, ".pc_next"}, id_pc_next,      e.pc_next);
        check({tag, ".valid"},   32'(id_valid),   32'(e.valid));
    endtask

    function automatic pkt_t bubble_of(input pkt_t prev);
        pkt_t b = prev;
        b.instr = 16'h0000;
        b.imm = '0;
        b.has_imm = 1'b0;
        b.valid = 1'b0;
        return b;
    endfunction

    // Reference: consumed words collect in a list; a complete instruction is emitted as
    // soon as the list holds either one non-immediate opcode or an opcode plus its data word.
    task automatic model_step(input logic v, input logic [15:0] w, input logic [31:0] pc,
                              input logic st, input logic fl);
        if (fl) begin
            pend.delete();
            model_out = bubble_of(model_out);
        end else if (st) begin
            model_out = model_out;
        end else if (!v) begin
            model_out = bubble_of(model_out);
        end else begin
            pend.push_back('{word: w, pc: pc});
            if (pend.size() == 1 && w[15:14] != 2'b11) begin
                model_out = '{instr: w, imm: 16'h0, has_imm: 1'b0, pc: pc,
                              pc_next: pc + 32'd1, valid: 1'b1};
                pend.delete();
            end else if (pend.size() == 2) begin
                model_out = '{instr: pend[0].word, imm: pend[1].word, has_imm: 1'b1,
                              pc: pend[0].pc, pc_next: pend[0].pc + 32'd2, valid: 1'b1};
                pend.delete();
            end else begin
                model_out = bubble_of(model_out);
            end
        end
    endtask

    task automatic step(input logic v, input logic [15:0] w, input logic [31:0] pc,
                        input logic st, input logic fl);
        if_valid = v;
        if_instr = w;
        if_pc    = pc;
        stall    = st;
        flush    = fl;
        model_step(v, w, pc, st, fl);
        exp_q.push_back(model_out);
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        drain();
        #1;
        rst = 1'b0;
        #1;
        check_pkt(tag, '{instr: 16'h0, imm: 16'h0, has_imm: 1'b0, pc: 32'h0,
                         pc_next: 32'h0, valid: 1'b0});
        pend.delete();
        model_out = '{instr: 16'h0, imm: 16'h0, has_imm: 1'b0, pc: 32'h0,
                      pc_next: 32'h0, valid: 1'b0};
        if_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst && exp_q.size() != 0) begin
            check_pkt("pkt", exp_q.pop_front());
        end
    end

    initial begin
        model_out = '0;
        #1;
        apply_reset("reset_initial");

        // Two single-word instructions back to back.
        step(1, 16'h1234, 32'h20, 0, 0);
        step(1, 16'h2345, 32'h21, 0, 0);
        step(0, 16'h0000, 32'h0, 0, 0);

        // Opcode plus immediate whose own top bits look imm-class.
        step(1, 16'hC105, 32'h30, 0, 0);
        step(1, 16'hFFFF, 32'h31, 0, 0);
        step(0, 16'h0000, 32'h0, 0, 0);

        // Stall for three cycles between opcode and immediate.
        step(1, 16'hC200, 32'h40, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 16'h1111, 32'h99, 1, 0);
        step(1, 16'hABCD, 32'h41, 0, 0);

        // Flush with stall while an opcode is pending, then a plain word.
        step(1, 16'hC300, 32'h50, 0, 0);
        step(1, 16'h7777, 32'h51, 1, 1);
        step(1, 16'h0042, 32'h52, 0, 0);

        // Idle cycles while pending, with a PC that wraps.
        step(1, 16'hD00D, 32'hFFFF_FFFF, 0, 0);
        step(0, 16'h5555, 32'h0, 0, 0);
        step(0, 16'h5555, 32'h0, 0, 0);
        step(1, 16'h0BEE, 32'h0, 0, 0);
        step(1, 16'h0001, 32'hFFFF_FFFF, 0, 0);

        // Reset while an opcode is pending: the next word decodes as a single instruction.
        step(1, 16'hC0DE, 32'h60, 0, 0);
        apply_reset("reset_mid_imm");
        step(1, 16'h0123, 32'h70, 0, 0);
        step(1, 16'hF000, 32'h71, 0, 0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] r = $urandom;
            logic [31:0] pc = (r[3:0] == 4'hF) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2))
                                               : $urandom;
            step(r[4] | r[5], r[6] ? {2'b11, 14'($urandom)} : 16'($urandom), pc,
                 r[9:7] == 3'b000, r[12:10] == 3'b000);
        end

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
